// File: rtl/pi_cmd_queue_pkg.sv
// Shared Pi register map and posted-command entry layout.
// Used by the Pi front end, the command queue and the 68k bus engine.
package pi_cmd_queue_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int STATUS_OVF_CLR_BIT = 15;

  // ADDR_HI write data bits that qualify the command
  localparam int AHI_SZ_BIT = 8;
  localparam int AHI_RW_BIT = 9;

  // spare is always written as 0
  typedef struct packed {
    logic        spare;
    logic [7:0]  a_hi;
    logic [15:1] a_lo;
    logic        a0;
    logic        sz;
    logic        rw;
    logic [15:0] d;
  } cmd_entry_t;

  localparam int ENTRY_W = $bits(cmd_entry_t);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFER,
    S_WAIT
  } ctl_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous DEPTH x ENTRY_W command FIFO with level count.
// Ports: push/wdata, pop/rdata (head, combinational), full, empty, level.
module cmd_fifo
  import pi_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   M68K_CLK,
  input  logic                   M68K_RESET,
  input  logic                   push,
  input  logic [ENTRY_W-1:0]     wdata,
  input  logic                   pop,
  output logic [ENTRY_W-1:0]     rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge M68K_CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge M68K_CLK) begin
    if (M68K_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/pi_cmd_queue.sv
// Posted-command queue: Pi register writes -> 68k bus commands.
// Ports: Pi write strobe/regs in, status out; CMD_* valid/ready; DONE in.
module pi_cmd_queue
  import pi_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   M68K_CLK,
  input  logic                   M68K_RESET,
  input  logic                   PI_WR_STB,
  input  logic [1:0]             PI_A,
  input  logic [15:0]            PI_D,
  output logic                   TXN_BUSY,
  output logic [15:0]            RD_DATA,
  output logic                   OVERFLOW,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   CMD_VALID,
  input  logic                   CMD_READY,
  output logic [22:0]            CMD_A,
  output logic                   CMD_A0,
  output logic                   CMD_SZ,
  output logic                   CMD_RW,
  output logic [15:0]            CMD_D,
  input  logic                   DONE,
  input  logic [15:0]            DONE_D
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [15:0]   stage_d;
  logic [15:1]   stage_a;
  logic          stage_a0;
  logic          wr_data;
  logic          wr_alo;
  logic          wr_ahi;
  logic          ovf_clr;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          rd_pend;
  logic          rp_nxt;
  logic          done_rd;
  logic [LW-1:0] lvl_nxt;
  cmd_entry_t    new_e;
  cmd_entry_t    head;
  ctl_state_t    state;
  logic          unused_ok;

  assign wr_data = PI_WR_STB & (PI_A == REG_DATA);
  assign wr_alo  = PI_WR_STB & (PI_A == REG_ADDR_LO);
  assign wr_ahi  = PI_WR_STB & (PI_A == REG_ADDR_HI);
  assign ovf_clr = PI_WR_STB & (PI_A == REG_STATUS)
                 & PI_D[STATUS_OVF_CLR_BIT];

  always_comb begin
    new_e      = '0;
    new_e.a_hi = PI_D[7:0];
    new_e.a_lo = stage_a;
    new_e.a0   = stage_a0;
    new_e.sz   = PI_D[AHI_SZ_BIT];
    new_e.rw   = PI_D[AHI_RW_BIT];
    new_e.d    = stage_d;
  end

  assign push    = wr_ahi & ~full;
  assign pop     = (state == S_OFFER) & CMD_READY;
  assign done_rd = (state == S_WAIT) & DONE & CMD_RW;
  assign rp_nxt  = (push & new_e.rw) | (rd_pend & ~done_rd);
  assign lvl_nxt = LEVEL + LW'(push) - LW'(pop);

  assign unused_ok = ^{PI_D[14:10], head.spare};

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .M68K_CLK  (M68K_CLK),
    .M68K_RESET(M68K_RESET),
    .push      (push),
    .wdata     (new_e),
    .pop       (pop),
    .rdata     (head),
    .full      (full),
    .empty     (empty),
    .level     (LEVEL)
  );

  always_ff @(posedge M68K_CLK) begin
    if (M68K_RESET) begin
      state     <= S_IDLE;
      stage_d   <= '0;
      stage_a   <= '0;
      stage_a0  <= 1'b0;
      rd_pend   <= 1'b0;
      OVERFLOW  <= 1'b0;
      TXN_BUSY  <= 1'b0;
      CMD_VALID <= 1'b0;
      RD_DATA   <= '0;
      CMD_A     <= '0;
      CMD_A0    <= 1'b0;
      CMD_SZ    <= 1'b0;
      CMD_RW    <= 1'b1;
      CMD_D     <= '0;
    end else begin
      if (wr_data) stage_d <= PI_D;
      if (wr_alo) begin
        stage_a  <= PI_D[15:1];
        stage_a0 <= PI_D[0];
      end
      if (wr_ahi && full) OVERFLOW <= 1'b1;
      else if (ovf_clr)   OVERFLOW <= 1'b0;
      rd_pend  <= rp_nxt;
      // busy follows the post-edge level so a filling commit shows at once
      TXN_BUSY <= (lvl_nxt == LW'(DEPTH)) | rp_nxt;
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            state     <= S_OFFER;
            CMD_VALID <= 1'b1;
            CMD_A     <= {head.a_hi, head.a_lo};
            CMD_A0    <= head.a0;
            CMD_SZ    <= head.sz;
            CMD_RW    <= head.rw;
            CMD_D     <= head.d;
          end
        end
        S_OFFER: begin
          if (CMD_READY) begin
            state     <= S_WAIT;
            CMD_VALID <= 1'b0;
          end
        end
        S_WAIT: begin
          if (DONE) begin
            if (CMD_RW) RD_DATA <= DONE_D;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_cmd_queue.sv
// Self-checking bench for pi_cmd_queue: directed cases plus random traffic
// checked against a queue-based model of the Pi and the bus engine.
module tb_pi_cmd_queue;
  import pi_cmd_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        M68K_CLK = 1'b0;
  logic        M68K_RESET;
  logic        PI_WR_STB;
  logic [1:0]  PI_A;
  logic [15:0] PI_D;
  logic        TXN_BUSY;
  logic [15:0] RD_DATA;
  logic        OVERFLOW;
  logic [2:0]  LEVEL;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [22:0] CMD_A;
  logic        CMD_A0;
  logic        CMD_SZ;
  logic        CMD_RW;
  logic [15:0] CMD_D;
  logic        DONE;
  logic [15:0] DONE_D;

  pi_cmd_queue #(.DEPTH(DEPTH)) dut (
    .M68K_CLK  (M68K_CLK),
    .M68K_RESET(M68K_RESET),
    .PI_WR_STB (PI_WR_STB),
    .PI_A      (PI_A),
    .PI_D      (PI_D),
    .TXN_BUSY  (TXN_BUSY),
    .RD_DATA   (RD_DATA),
    .OVERFLOW  (OVERFLOW),
    .LEVEL     (LEVEL),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_A     (CMD_A),
    .CMD_A0    (CMD_A0),
    .CMD_SZ    (CMD_SZ),
    .CMD_RW    (CMD_RW),
    .CMD_D     (CMD_D),
    .DONE      (DONE),
    .DONE_D    (DONE_D)
  );

  always #5 M68K_CLK = ~M68K_CLK;

  typedef struct {
    logic [22:0] a;
    logic        a0;
    logic        sz;
    logic        rw;
    logic [15:0] d;
  } tcmd_t;

  tcmd_t       q[$];
  logic [15:0] m_sd;
  logic [15:1] m_sa;
  logic        m_sa0;
  bit          m_ovf;
  bit          m_rp;
  bit          m_out;
  bit          m_out_rw;
  logic [15:0] m_rd;
  int          out_age;
  int          errs = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_sd = '0; m_sa = '0; m_sa0 = 1'b0;
    m_ovf = 0; m_rp = 0; m_out = 0; m_out_rw = 0;
    m_rd = '0; out_age = 0;
  endtask

  // one clock: check any accept against the model head, then update
  // the model with the inputs seen at the edge and compare status
  task automatic step();
    bit    acc;
    bit    full_pre;
    tcmd_t c;
    acc = (CMD_VALID === 1'b1) && CMD_READY;
    if (acc && q.size() != 0) begin
      c = q[0];
      check("cmd_a", CMD_A, c.a);
      check("cmd_a0", CMD_A0, c.a0);
      check("cmd_sz", CMD_SZ, c.sz);
      check("cmd_rw", CMD_RW, c.rw);
      check("cmd_d", CMD_D, c.d);
    end
    full_pre = (q.size() == DEPTH);
    @(posedge M68K_CLK);
    #1;
    if (M68K_RESET) begin
      m_reset();
    end else begin
      if (m_out && DONE) begin
        if (m_out_rw) begin
          m_rd = DONE_D;
          m_rp = 0;
        end
        m_out = 0;
      end
      if (acc && q.size() != 0) begin
        m_out_rw = q[0].rw;
        void'(q.pop_front());
        m_out = 1;
        out_age = 0;
      end else if (m_out) begin
        out_age++;
      end
      if (PI_WR_STB) begin
        unique case (PI_A)
          REG_DATA: m_sd = PI_D;
          REG_ADDR_LO: begin
            m_sa = PI_D[15:1];
            m_sa0 = PI_D[0];
          end
          REG_ADDR_HI: begin
            if (full_pre) m_ovf = 1;
            else begin
              c.a = {PI_D[7:0], m_sa};
              c.a0 = m_sa0;
              c.sz = PI_D[8];
              c.rw = PI_D[9];
              c.d = m_sd;
              q.push_back(c);
              if (c.rw) m_rp = 1;
            end
          end
          default: if (PI_D[15]) m_ovf = 0;
        endcase
      end
    end
    check("level", LEVEL, q.size());
    check("busy", TXN_BUSY, (q.size() == DEPTH) || m_rp);
    check("ovf", OVERFLOW, m_ovf);
    check("rd_data", RD_DATA, m_rd);
    if (m_out || q.size() == 0) check("valid_idle", CMD_VALID, 0);
  endtask

  task automatic pi_wr(input logic [1:0] a, input logic [15:0] d);
    PI_WR_STB = 1'b1;
    PI_A = a;
    PI_D = d;
    step();
    PI_WR_STB = 1'b0;
  endtask

  task automatic engine(input bit rnd);
    CMD_READY = rnd ? 1'($urandom % 2) : 1'b1;
    DONE = 1'b0;
    if (m_out && (rnd ? ($urandom % 3 == 0) : (out_age >= 1))) begin
      DONE = 1'b1;
      DONE_D = 16'($urandom);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || m_out) && n < budget) begin
      engine(0);
      step();
      n++;
    end
    CMD_READY = 1'b0;
    DONE = 1'b0;
    check("drain_in_budget", 32'(n < budget), 1);
  endtask

  initial begin
    int          lvl;
    logic [1:0]  ra;
    logic [15:0] rdv;
    M68K_RESET = 1'b1;
    PI_WR_STB = 1'b0; PI_A = '0; PI_D = '0;
    CMD_READY = 1'b0; DONE = 1'b0; DONE_D = '0;
    m_reset();
    step();
    step();
    M68K_RESET = 1'b0;
    check("rst_valid", CMD_VALID, 0);
    check("rst_rw", CMD_RW, 1);
    check("rst_a", CMD_A, 0);
    check("rst_d", CMD_D, 0);
    check("rst_sz", CMD_SZ, 0);

    // posted write, 1-cycle commit to offer
    pi_wr(REG_ADDR_LO, 16'hBFE0);
    pi_wr(REG_DATA, 16'h1234);
    pi_wr(REG_ADDR_HI, 16'h0000);
    check("lat_commit_edge", CMD_VALID, 0);
    step();
    check("lat_valid", CMD_VALID, 1);
    check("t1_a", CMD_A, 23'h005FF0);
    check("t1_rw", CMD_RW, 0);
    check("t1_d", CMD_D, 16'h1234);
    check("t1_busy", TXN_BUSY, 0);
    CMD_READY = 1'b1;
    step();
    CMD_READY = 1'b0;
    check("acc_valid_low", CMD_VALID, 0);
    pi_wr(REG_ADDR_HI, 16'h0000);
    step();
    DONE = 1'b1; DONE_D = 16'h5555;
    step();
    DONE = 1'b0;
    check("done_p1", CMD_VALID, 0);
    step();
    check("done_p2", CMD_VALID, 1);
    drain(20);

    // non-posted read
    pi_wr(REG_ADDR_HI, 16'h0200);
    check("rd_busy_commit", TXN_BUSY, 1);
    step();
    CMD_READY = 1'b1;
    step();
    CMD_READY = 1'b0;
    step();
    check("rd_busy_wait", TXN_BUSY, 1);
    DONE = 1'b1; DONE_D = 16'hBEEF;
    step();
    DONE = 1'b0;
    check("rd_result", RD_DATA, 16'hBEEF);
    check("rd_busy_done", TXN_BUSY, 0);

    // overflow on fifth commit
    for (int i = 0; i < 5; i++) pi_wr(REG_ADDR_HI, 16'(i + 8'h10));
    check("ovf_level", LEVEL, 4);
    check("ovf_busy", TXN_BUSY, 1);
    check("ovf_set", OVERFLOW, 1);
    pi_wr(REG_STATUS, 16'h7FFF);
    check("ovf_hold", OVERFLOW, 1);
    pi_wr(REG_STATUS, 16'h8000);
    check("ovf_clr", OVERFLOW, 0);
    drain(60);

    // commit in the accept cycle
    pi_wr(REG_ADDR_HI, 16'h0001);
    pi_wr(REG_ADDR_HI, 16'h0002);
    lvl = q.size();
    CMD_READY = 1'b1;
    pi_wr(REG_ADDR_HI, 16'h0003);
    CMD_READY = 1'b0;
    check("same_cycle_lvl", LEVEL, lvl);
    drain(40);

    // reset while waiting on the bus engine
    pi_wr(REG_ADDR_HI, 16'h0004);
    pi_wr(REG_ADDR_HI, 16'h0005);
    pi_wr(REG_ADDR_HI, 16'h0006);
    CMD_READY = 1'b1;
    step();
    CMD_READY = 1'b0;
    check("wait_lvl", LEVEL, 2);
    M68K_RESET = 1'b1;
    step();
    M68K_RESET = 1'b0;
    check("abort_lvl", LEVEL, 0);
    check("abort_valid", CMD_VALID, 0);
    check("abort_busy", TXN_BUSY, 0);
    DONE = 1'b1; DONE_D = 16'hDEAD;
    step();
    DONE = 1'b0;
    check("abort_rd", RD_DATA, 0);

    // random traffic; Pi honours read-pending, sometimes ignores full
    for (int i = 0; i < 3000; i++) begin
      engine(1);
      if ($urandom % 3 == 0) begin
        ra = 2'($urandom);
        rdv = 16'($urandom);
        if (ra == REG_ADDR_HI) begin
          if (m_rp) ra = REG_DATA;
          else if (q.size() == DEPTH && $urandom % 2 == 1) ra = REG_DATA;
        end
        pi_wr(ra, rdv);
      end else begin
        step();
      end
    end
    DONE = 1'b0;
    drain(200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
